// File: rtl/cache_ram_ctrl.sv
// rtl/cache_ram_ctrl.sv - write-side sequencer for one cache way's tag_ram and data_ram
module cache_ram_ctrl #(
    parameter int INDEX_WIDTH  = 7,
    parameter int TAG_WIDTH    = 20,
    parameter int OFFSET_WIDTH = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    output logic                              o_init_done,
    input  logic                              i_refill_req,
    input  logic [INDEX_WIDTH-1:0]            i_refill_index,
    input  logic [TAG_WIDTH-1:0]              i_refill_tag,
    output logic                              o_refill_ack,
    input  logic                              i_beat_valid,
    input  logic [31:0]                       i_beat_data,
    output logic                              o_refill_done,
    input  logic                              i_inv_req,
    input  logic [INDEX_WIDTH-1:0]            i_inv_index,
    output logic                              o_inv_ready,
    input  logic                              i_st_req,
    input  logic [INDEX_WIDTH-1:0]            i_st_index,
    input  logic [OFFSET_WIDTH-1:0]           i_st_offset,
    input  logic [3:0]                        i_st_wbyteen,
    input  logic [31:0]                       i_st_wdata,
    output logic                              o_st_ready,
    output logic                              o_tag_wen,
    output logic [INDEX_WIDTH-1:0]            o_tag_waddr,
    output logic [TAG_WIDTH:0]                o_tag_wdata,
    output logic                              o_data_wen,
    output logic [3:0]                        o_data_wbyteen,
    output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] o_data_waddr,
    output logic [31:0]                       o_data_wdata
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_REFILL, S_PUBLISH} state_t;

    state_t                               state_q;
    logic [INDEX_WIDTH:0]                 sweep_q;
    logic [INDEX_WIDTH-1:0]               idx_q;
    logic [TAG_WIDTH-1:0]                 tag_q;
    logic [OFFSET_WIDTH-1:0]              cnt_q;
    logic                                 init_done_q;
    logic                                 refill_done_q;
    logic                                 tag_wen_q;
    logic [INDEX_WIDTH-1:0]               tag_waddr_q;
    logic [TAG_WIDTH:0]                   tag_wdata_q;
    logic                                 data_wen_q;
    logic [3:0]                           data_wbyteen_q;
    logic [INDEX_WIDTH+OFFSET_WIDTH-1:0]  data_waddr_q;
    logic [31:0]                          data_wdata_q;

    assign o_refill_ack = (state_q == S_IDLE) & i_refill_req;
    assign o_inv_ready  = (state_q == S_IDLE) & ~i_refill_req;
    assign o_st_ready   = (state_q == S_IDLE) & ~i_refill_req & ~i_inv_req;

    assign o_init_done    = init_done_q;
    assign o_refill_done  = refill_done_q;
    assign o_tag_wen      = tag_wen_q;
    assign o_tag_waddr    = tag_waddr_q;
    assign o_tag_wdata    = tag_wdata_q;
    assign o_data_wen     = data_wen_q;
    assign o_data_wbyteen = data_wbyteen_q;
    assign o_data_waddr   = data_waddr_q;
    assign o_data_wdata   = data_wdata_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_INIT;
            sweep_q        <= '0;
            idx_q          <= '0;
            tag_q          <= '0;
            cnt_q          <= '0;
            init_done_q    <= 1'b0;
            refill_done_q  <= 1'b0;
            tag_wen_q      <= 1'b0;
            tag_waddr_q    <= '0;
            tag_wdata_q    <= '0;
            data_wen_q     <= 1'b0;
            data_wbyteen_q <= '0;
            data_waddr_q   <= '0;
            data_wdata_q   <= '0;
        end else begin
            tag_wen_q     <= 1'b0;
            data_wen_q    <= 1'b0;
            refill_done_q <= 1'b0;
            case (state_q)
                // Extra sweep bit holds INIT one cycle past the last clear so
                // init_done rises only after that write is on the port.
                S_INIT: begin
                    if (sweep_q[INDEX_WIDTH]) begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        tag_wen_q   <= 1'b1;
                        tag_waddr_q <= sweep_q[INDEX_WIDTH-1:0];
                        tag_wdata_q <= '0;
                        sweep_q     <= sweep_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_refill_req) begin
                        idx_q       <= i_refill_index;
                        tag_q       <= i_refill_tag;
                        cnt_q       <= '0;
                        tag_wen_q   <= 1'b1;
                        tag_waddr_q <= i_refill_index;
                        tag_wdata_q <= {1'b0, i_refill_tag};
                        state_q     <= S_REFILL;
                    end else if (i_inv_req) begin
                        tag_wen_q   <= 1'b1;
                        tag_waddr_q <= i_inv_index;
                        tag_wdata_q <= '0;
                    end else if (i_st_req) begin
                        data_wen_q     <= 1'b1;
                        data_wbyteen_q <= i_st_wbyteen;
                        data_waddr_q   <= {i_st_index, i_st_offset};
                        data_wdata_q   <= i_st_wdata;
                    end
                end
                S_REFILL: begin
                    if (i_beat_valid) begin
                        data_wen_q     <= 1'b1;
                        data_wbyteen_q <= 4'hF;
                        data_waddr_q   <= {idx_q, cnt_q};
                        data_wdata_q   <= i_beat_data;
                        cnt_q          <= cnt_q + 1'b1;
                        if (cnt_q == '1) begin
                            state_q <= S_PUBLISH;
                        end
                    end
                end
                S_PUBLISH: begin
                    tag_wen_q     <= 1'b1;
                    tag_waddr_q   <= idx_q;
                    tag_wdata_q   <= {1'b1, tag_q};
                    refill_done_q <= 1'b1;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

endmodule
